// File: rtl/async_to_sync_fifo_ctrl_pkg.sv
// Shared types for the async req/ack to sync valid/ready bridge.
// Holds the write FSM state encoding and the level width helper.
package async_to_sync_fifo_ctrl_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } wr_state_e;

  // Level must represent 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/async_to_sync_fifo_ctrl_sync_fifo_fwft.sv
// First-word fall-through FIFO with occupancy counter.
// Ports: wr_en/wr_d/full, rd_en/rd_d/empty, level; async active-low reset.
module sync_fifo_fwft
  import async_to_sync_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int LEVEL_W = level_w(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_d,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_d,
  output logic                  empty,
  output logic [LEVEL_W-1:0]    level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0]    level_q, level_d;
  logic                  do_wr, do_rd;

  // Full/empty come from the registered level only, so a write
  // against a full FIFO waits even if a pop happens this cycle.
  assign full  = (level_q == LEVEL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  assign rd_d  = mem_q[rd_ptr_q];
  assign level = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_d;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case (1'b1)
      (do_wr & ~do_rd): level_d = level_q + LEVEL_W'(1);
      (do_rd & ~do_wr): level_d = level_q - LEVEL_W'(1);
      default:          level_d = level_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/async_to_sync_fifo_ctrl.sv
// 4-phase async req/ack to sync valid/ready bridge with FWFT buffer.
// Ports: async_req/ack/d in, sync_valid/ready/d out, level, proto_err.
module async_to_sync_fifo_ctrl
  import async_to_sync_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SYNC_STAGE = 2,
  parameter int DEPTH = 4,
  localparam int LEVEL_W = level_w(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  async_req,
  output logic                  async_ack,
  input  logic [DATA_WIDTH-1:0] async_d,
  output logic                  sync_valid,
  input  logic                  sync_ready,
  output logic [DATA_WIDTH-1:0] sync_d,
  output logic [LEVEL_W-1:0]    level,
  output logic                  proto_err
);

  logic                  req_s;
  logic [DATA_WIDTH-1:0] d_s;

  // Data rides the same pipeline depth as req so both arrive together.
  if (SYNC_STAGE == 0) begin : g_nosync
    assign req_s = async_req;
    assign d_s   = async_d;
  end else begin : g_sync
    logic [SYNC_STAGE-1:0]                 req_pipe_q, req_pipe_d;
    logic [SYNC_STAGE-1:0][DATA_WIDTH-1:0] d_pipe_q, d_pipe_d;

    always_comb begin
      req_pipe_d    = req_pipe_q;
      d_pipe_d      = d_pipe_q;
      req_pipe_d[0] = async_req;
      d_pipe_d[0]   = async_d;
      for (int i = 1; i < SYNC_STAGE; i++) begin
        req_pipe_d[i] = req_pipe_q[i-1];
        d_pipe_d[i]   = d_pipe_q[i-1];
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        req_pipe_q <= '0;
        d_pipe_q   <= '0;
      end else begin
        req_pipe_q <= req_pipe_d;
        d_pipe_q   <= d_pipe_d;
      end
    end

    assign req_s = req_pipe_q[SYNC_STAGE-1];
    assign d_s   = d_pipe_q[SYNC_STAGE-1];
  end

  wr_state_e state_q, state_d;
  logic      ack_q, ack_d;
  logic      err_q, err_d;
  logic      req_prev_q;
  logic      wr_en;
  logic      full, empty;

  // In IDLE a previous req_s=1 can only mean a stall (an accepted
  // request leaves IDLE), so a falling req_s here is a withdrawal.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_s && !full) begin
          wr_en   = 1'b1;
          ack_d   = 1'b1;
          state_d = WAIT_LOW;
        end else if (!req_s && req_prev_q) begin
          err_d = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      req_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      req_prev_q <= req_s;
    end
  end

  sync_fifo_fwft #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .wr_en(wr_en),
    .wr_d (d_s),
    .full (full),
    .rd_en(sync_ready),
    .rd_d (sync_d),
    .empty(empty),
    .level(level)
  );

  assign sync_valid = ~empty;
  assign async_ack  = ack_q;
  assign proto_err  = err_q;

endmodule

// File: tb/tb_async_to_sync_fifo_ctrl.sv
// Bench for async_to_sync_fifo_ctrl: scoreboard on popped words,
// directed handshake/level/error checks, SYNC_STAGE=2 and =0 builds.
module tb_async_to_sync_fifo_ctrl;

  logic       clock;
  logic       a_rst, a_req, a_ack, a_valid, a_ready, a_err;
  logic [7:0] a_d, a_sd;
  logic [2:0] a_lvl;
  logic       b_rst, b_req, b_ack, b_valid, b_ready, b_err;
  logic [7:0] b_d, b_sd;
  logic [2:0] b_lvl;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [$];

  async_to_sync_fifo_ctrl #(
    .DATA_WIDTH(8), .SYNC_STAGE(2), .DEPTH(4)
  ) dut_a (
    .clock(clock), .reset(a_rst),
    .async_req(a_req), .async_ack(a_ack), .async_d(a_d),
    .sync_valid(a_valid), .sync_ready(a_ready), .sync_d(a_sd),
    .level(a_lvl), .proto_err(a_err)
  );

  async_to_sync_fifo_ctrl #(
    .DATA_WIDTH(8), .SYNC_STAGE(0), .DEPTH(4)
  ) dut_b (
    .clock(clock), .reset(b_rst),
    .async_req(b_req), .async_ack(b_ack), .async_d(b_d),
    .sync_valid(b_valid), .sync_ready(b_ready), .sync_d(b_sd),
    .level(b_lvl), .proto_err(b_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ack(input logic v, input string nm);
    int n = 0;
    while (a_ack !== v && n < 30) begin
      tick();
      n++;
    end
    chk(nm, a_ack, v);
  endtask

  task automatic send(input logic [7:0] d);
    a_d   = d;
    a_req = 1'b1;
    sb.push_back(d);
    wait_ack(1'b1, "send_ack_hi");
    a_req = 1'b0;
    wait_ack(1'b0, "send_ack_lo");
  endtask

  task automatic drain();
    int n = 0;
    a_ready = 1'b1;
    while (a_valid && n < 30) begin
      tick();
      n++;
    end
    a_ready = 1'b0;
    chk("drain_empty", a_valid, 1'b0);
  endtask

  // Monitor: every accepted word is checked against the scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (a_rst && a_valid && a_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow act=%0h exp=none", a_sd);
        end else begin
          e = sb.pop_front();
          chk("pop_data", a_sd, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=done");
    $fatal(1, "timeout");
  end

  initial begin
    int saw;
    a_rst = 0; a_req = 0; a_d = 0; a_ready = 0;
    b_rst = 0; b_req = 0; b_d = 0; b_ready = 0;
    #1;
    chk("rst_ack", a_ack, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_sd", a_sd, 0);
    chk("rst_lvl", a_lvl, 0);
    chk("rst_err", a_err, 0);
    tick(); tick();
    a_rst = 1; b_rst = 1;
    tick();

    // Single word: ack and data appear at E0+2.
    a_d = 8'hA5; a_req = 1; sb.push_back(8'hA5);
    tick();
    chk("lat_e0_ack", a_ack, 0);
    tick();
    chk("lat_e1_ack", a_ack, 0);
    chk("lat_e1_valid", a_valid, 0);
    tick();
    chk("lat_e2_ack", a_ack, 1);
    chk("lat_e2_valid", a_valid, 1);
    chk("lat_e2_sd", a_sd, 8'hA5);
    chk("lat_e2_lvl", a_lvl, 1);
    a_req = 0;
    tick(); tick();
    chk("fall_f1_ack", a_ack, 1);
    tick();
    chk("fall_f2_ack", a_ack, 0);
    a_ready = 1;
    tick();
    a_ready = 0;
    chk("pop1_valid", a_valid, 0);
    chk("pop1_lvl", a_lvl, 0);

    // Burst into full FIFO, fifth word stalls until a pop.
    for (int i = 1; i <= 4; i++) send(8'(i));
    chk("burst_lvl4", a_lvl, 4);
    a_d = 8'h05; a_req = 1; sb.push_back(8'h05);
    saw = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (a_ack) saw++;
    end
    chk("stall_ack", saw, 0);
    chk("stall_lvl", a_lvl, 4);
    a_ready = 1;
    tick();
    a_ready = 0;
    chk("stall_pop_lvl", a_lvl, 3);
    chk("stall_pop_ack", a_ack, 0);
    wait_ack(1, "stall_rel_ack");
    chk("stall_rel_lvl", a_lvl, 4);
    a_req = 0;
    wait_ack(0, "stall_ack_lo");
    chk("stall_err", a_err, 0);
    drain();
    chk("burst_lvl0", a_lvl, 0);

    // Push and pop on the same edge at level 2, across wrap.
    send(8'h10);
    send(8'h11);
    chk("pp_lvl2", a_lvl, 2);
    for (int i = 2; i < 10; i++) begin
      a_d = 8'(8'h10 + i); a_req = 1; sb.push_back(a_d);
      tick(); tick();
      a_ready = 1;
      tick();
      a_ready = 0;
      chk("pp_ack", a_ack, 1);
      chk("pp_lvl", a_lvl, 2);
      a_req = 0;
      wait_ack(0, "pp_ack_lo");
    end
    drain();

    // Withdraw a stalled request.
    for (int i = 0; i < 4; i++) send(8'(8'h20 + i));
    a_d = 8'h24; a_req = 1;
    for (int i = 0; i < 4; i++) tick();
    a_req = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("wd_err", a_err, 1);
    chk("wd_lvl", a_lvl, 4);
    chk("wd_ack", a_ack, 0);
    tick(); tick(); tick();
    chk("wd_err_sticky", a_err, 1);
    a_rst = 0;
    #1;
    sb.delete();
    chk("wd_rst_err", a_err, 0);
    chk("wd_rst_lvl", a_lvl, 0);
    tick();
    a_rst = 1;
    tick();

    // Reset mid-burst with ack high.
    send(8'h30);
    send(8'h31);
    a_d = 8'h32; a_req = 1; sb.push_back(8'h32);
    wait_ack(1, "mid_ack_hi");
    chk("mid_lvl3", a_lvl, 3);
    a_rst = 0;
    #1;
    sb.delete();
    chk("mid_rst_ack", a_ack, 0);
    chk("mid_rst_valid", a_valid, 0);
    chk("mid_rst_lvl", a_lvl, 0);
    chk("mid_rst_sd", a_sd, 0);
    a_req = 0;
    tick(); tick();
    a_rst = 1;
    tick();

    // SYNC_STAGE=0 build: write on the first edge.
    b_d = 8'h3C; b_req = 1;
    #1;
    chk("b_pre_ack", b_ack, 0);
    tick();
    chk("b_ack", b_ack, 1);
    chk("b_valid", b_valid, 1);
    chk("b_sd", b_sd, 8'h3C);
    chk("b_lvl", b_lvl, 1);
    b_req = 0;
    tick();
    chk("b_ack_lo", b_ack, 0);
    chk("b_err", b_err, 0);

    tick(); tick();
    chk("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/async_to_sync_fifo_ctrl.md
Name: async_to_sync_fifo_ctrl

Overview:
- Next-generation async req/ack to sync valid/ready bridge for the UART datapath.
- Adds a parametrised FIFO of depth DEPTH, so the async sender is acknowledged as soon as its word is buffered, not when the sync consumer accepts it.
- Adds fill level reporting and a sticky protocol-violation flag.
- Supports SYNC_STAGE=0 (async_req used directly, as in the previous generation).

Parameters:
DATA_WIDTH, 8, width of async_d / sync_d
SYNC_STAGE, 2, synchronizer flops on async_req (0 = no synchronizer)
DEPTH, 4, FIFO entries; power of two, >=2
LEVEL_W, $clog2(DEPTH+1), width of level output (derived localparam)

Ports:
clock  input  1  single clock for all logic
reset  input  1  asynchronous, active-low reset
async_req  input  1  4-phase request from async sender
async_ack  output  1  4-phase acknowledge to sender
async_d  input  DATA_WIDTH  data; stable while async_req=1
sync_valid  output  1  FIFO non-empty
sync_ready  input  1  consumer accept
sync_d  output  DATA_WIDTH  head-of-FIFO data (first-word fall-through)
level  output  LEVEL_W  current FIFO occupancy, 0..DEPTH
proto_err  output  1  sticky: request withdrawn before ack

Behaviour:
- Reset (reset=0, asynchronous):
  - async_ack=0, sync_valid=0, sync_d=0, level=0, proto_err=0.
  - Synchronizer flops, pointers and memory cleared; FSM in IDLE.
  - Reset mid-transfer discards buffered data; sender sees ack drop immediately.
- Synchronization:
  - req_s = async_req delayed by SYNC_STAGE flops (req_s = async_req when SYNC_STAGE=0).
  - async_d goes through an identically delayed DATA_WIDTH pipeline, giving d_s aligned with req_s.
- Write FSM states:
  - IDLE:
    - req_s=1 & !full -> write d_s at wr_ptr, async_ack<=1, go WAIT_LOW.
    - req_s=1 & full -> stay IDLE (stall, ack held 0).
    - req_s falls while stalled (seen 1 last cycle, 0 now, no ack given) -> proto_err<=1, stay IDLE, no write.
  - WAIT_LOW:
    - req_s=0 -> async_ack<=0, go IDLE.
    - Otherwise hold ack=1.
- Latency:
  - Let async_req rise before edge E0.
  - With FIFO not full, write and ack occur at edge E0+SYNC_STAGE.
  - sync_valid=1 and sync_d=word are visible after that same edge.
  - ack deasserts at the edge SYNC_STAGE edges after async_req falls.
- Read side:
  - sync_valid = !empty; sync_d = mem[rd_ptr].
  - Pop on sync_valid & sync_ready; pop while empty is impossible.
- Full/empty decisions use registered state:
  - A write is blocked when full, even if a pop happens in the same cycle. The write proceeds on the next edge.
  - Simultaneous write and pop when not full and not empty: level unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally.
  - Full/empty come from the level counter, updated +1 on write only, -1 on pop only, unchanged otherwise.
- At most one FIFO write per 4-phase cycle: a new write requires a return through WAIT_LOW to IDLE.
- proto_err clears only on reset.

Decomposition:
- Shared header: FSM state encoding (IDLE, WAIT_LOW) and the LEVEL_W computation.
- One sub-module, sync_fifo_fwft:
  - Parameters DATA_WIDTH, DEPTH.
  - Ports wr_en/wr_d/full, rd_en/rd_d/empty, level.
  - Same clock/reset convention.
- The synchronizer pipeline and write FSM stay in the top module.

Test Plan:
- Single word, SYNC_STAGE=2: async_req=1 with async_d=0xA5 -> ack=1 and sync_valid=1, sync_d=0xA5 after exactly 2 edges. Then sync_ready=1 -> valid=0, level=0.
- Burst with sync_ready=0, DEPTH=4: send 0x01..0x05 -> first 4 acked, level=4. 5th req stalls with ack=0 until one pop. Popped order is 0x01..0x05.
- Simultaneous push/pop at level=2 -> level stays 2, data order preserved across pointer wrap (10 words total).
- Withdraw req while stalled on full -> proto_err=1 and stays 1, level unchanged. Reset -> proto_err=0.
- Assert reset (0) mid-burst at level=3 with ack=1 -> ack, sync_valid, level go to 0 without a clock edge.
- SYNC_STAGE=0 build: req with 0x3C -> ack and sync_valid after 1 edge, sync_d=0x3C.
